l2_cache_nway: RTL and testbench

L2_CACHE_NWAY -- requirements
Module: l2_cache_nway

---
 rtl/lc3b_types.sv | 20 ++
 rtl/plru_tree.sv | 30 +++
 rtl/l2_cache_nway.sv | 205 ++++++++++++++++++++
 tb/tb_l2_cache_nway.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared word/line types and the cache controller state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;
  typedef logic [255:0] lc3b_256;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWriteback,
    StAllocate,
    StPfCheck,
    StPfFill
  } cache_state_e;

  // Highest line address; the next line would wrap to zero.
  localparam lc3b_word LastLine = 16'hFFE0;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim walk and MRU update, purely combinational.
module plru_tree #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         bits,
  input  logic [$clog2(WAYS)-1:0] access_way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         bits_next
);

  localparam int unsigned Levels = $clog2(WAYS);

  logic [Levels-1:0] vnode;
  logic [Levels-1:0] unode;

  // A node bit names the subtree holding the victim; an access points it at the sibling.
  always_comb begin
    victim    = '0;
    bits_next = bits;
    vnode     = '0;
    unode     = '0;
    for (int l = 0; l < int'(Levels); l++) begin
      victim[Levels-1-l] = bits[vnode];
      vnode = bits[vnode] ? (vnode << 1) + Levels'(2) : (vnode << 1) + Levels'(1);
      bits_next[unode] = ~access_way[Levels-1-l];
      unode = access_way[Levels-1-l] ? (unode << 1) + Levels'(2) : (unode << 1) + Levels'(1);
    end
  end

endmodule

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back cache with 32-byte lines, 128-bit upstream
// half-line port, tree PLRU replacement and optional next-line prefetch.
module l2_cache_nway
  import lc3b_types::*;
#(
  parameter int unsigned WAYS        = 4,
  parameter int unsigned SETS        = 8,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  lc3b_word       mem_address,
  input  logic           mem_read,
  input  logic           mem_write,
  input  lc3b_cache_line mem_wdata,
  output lc3b_cache_line mem_rdata,
  output logic           mem_resp,
  output lc3b_word       pmem_address,
  output logic           pmem_read,
  output logic           pmem_write,
  output lc3b_256        pmem_wdata,
  input  lc3b_256        pmem_rdata,
  input  logic           pmem_resp,
  output logic [15:0]    hit_count,
  output logic [15:0]    miss_count
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 11 - IDX_W;
  localparam int unsigned WAY_W = $clog2(WAYS);

  cache_state_e state_q, state_d;

  lc3b_word       req_addr_q;
  lc3b_cache_line wdata_q;
  logic           is_write_q;
  logic           first_q;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAYS-2:0]  plru_q  [SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  lc3b_256          data_q  [WAYS][SETS];

  lc3b_word         req_line, pf_line, cur_line;
  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] cur_tag;
  logic             in_pf, pf_ok;

  logic             hit, inv_found, victim_dirty;
  logic [WAY_W-1:0] hit_way, inv_way, plru_victim, victim, plru_way;
  logic [WAYS-2:0]  plru_next;
  lc3b_256          hit_line;

  logic latch_en, fill_en, wr_hit_en, plru_en, hit_inc, miss_inc;

  assign req_line = req_addr_q & ~16'h001F;
  assign pf_line  = req_line + 16'd32;
  assign pf_ok    = (req_line != LastLine);
  assign in_pf    = (state_q == StPfCheck) || (state_q == StPfFill);
  assign cur_line = in_pf ? pf_line : req_line;
  assign cur_idx  = cur_line[5 +: IDX_W];
  assign cur_tag  = cur_line[15 -: TAG_W];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[cur_idx][w] && (tag_q[w][cur_idx] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[cur_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim       = inv_found ? inv_way : plru_victim;
  assign victim_dirty = valid_q[cur_idx][victim] && dirty_q[cur_idx][victim];
  assign plru_way     = (state_q == StCheck) ? hit_way : victim;

  plru_tree #(
    .WAYS(WAYS)
  ) u_plru (
    .bits      (plru_q[cur_idx]),
    .access_way(plru_way),
    .victim    (plru_victim),
    .bits_next (plru_next)
  );

  assign hit_line   = data_q[hit_way][cur_idx];
  assign mem_rdata  = req_addr_q[4] ? hit_line[255:128] : hit_line[127:0];
  assign pmem_wdata = data_q[victim][cur_idx];

  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    fill_en      = 1'b0;
    wr_hit_en    = 1'b0;
    plru_en      = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_read || mem_write) begin
          latch_en = 1'b1;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        // Counters classify each demand access once, on its first lookup only.
        if (hit) begin
          mem_resp  = 1'b1;
          plru_en   = 1'b1;
          hit_inc   = first_q;
          wr_hit_en = is_write_q;
          state_d   = (!is_write_q && PREFETCH_EN) ? StPfCheck : StIdle;
        end else begin
          miss_inc = first_q;
          state_d  = victim_dirty ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim][cur_idx], cur_idx, 5'b0};
        if (pmem_resp) state_d = StAllocate;
      end
      StAllocate: begin
        pmem_read    = 1'b1;
        pmem_address = cur_line;
        if (pmem_resp) begin
          fill_en = 1'b1;
          state_d = StCheck;
        end
      end
      StPfCheck: begin
        state_d = (!pf_ok || hit || victim_dirty) ? StIdle : StPfFill;
      end
      StPfFill: begin
        pmem_read    = 1'b1;
        pmem_address = cur_line;
        if (pmem_resp) begin
          fill_en = 1'b1;
          plru_en = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      req_addr_q <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      first_q    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == StCheck) first_q <= 1'b0;
      if (latch_en) begin
        req_addr_q <= mem_address;
        wdata_q    <= mem_wdata;
        is_write_q <= mem_write;
        first_q    <= 1'b1;
      end
      if (hit_inc && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
      if (miss_inc && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
      if (fill_en) begin
        valid_q[cur_idx][victim] <= 1'b1;
        dirty_q[cur_idx][victim] <= 1'b0;
      end
      if (wr_hit_en) dirty_q[cur_idx][hit_way] <= 1'b1;
      if (plru_en) plru_q[cur_idx] <= plru_next;
    end
  end

  // Data and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[victim][cur_idx] <= pmem_rdata;
      tag_q[victim][cur_idx]  <= cur_tag;
    end else if (wr_hit_en) begin
      if (req_addr_q[4]) data_q[hit_way][cur_idx][255:128] <= wdata_q;
      else               data_q[hit_way][cur_idx][127:0]   <= wdata_q;
    end
  end

endmodule

// File: tb/tb_l2_cache_nway.sv
// Bench for l2_cache_nway: flat-memory reference model, scoreboarded upstream
// responses, a randomly delayed physical memory, directed and random traffic.
module tb_l2_cache_nway;

  logic         clk, reset_n;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count, miss_count;

  int n_tests = 0;
  int n_fail  = 0;

  // phys: what physical memory holds; arch: what a CPU should observe.
  logic [255:0] phys [int];
  logic [255:0] arch [int];

  typedef struct {
    bit           is_write;
    logic [127:0] data;
  } exp_t;
  exp_t sb [$];

  logic [16:0] oplog   [$];
  logic [16:0] exp_ops [$];
  bit          prev_resp;
  int          lat;

  l2_cache_nway #(
    .WAYS       (4),
    .SETS       (8),
    .PREFETCH_EN(1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .pmem_address(pmem_address),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] init_line(int a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = (a * 32'h9E37_79B9) ^ (k * 32'h0101_0101) ^ 32'h5A5A_0000;
    return l;
  endfunction

  function automatic logic [255:0] get_phys(int a);
    if (phys.exists(a)) return phys[a];
    return init_line(a);
  endfunction

  function automatic logic [255:0] get_arch(int a);
    if (arch.exists(a)) return arch[a];
    return get_phys(a);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, oplog.size(), exp_ops.size());
    if (oplog.size() == exp_ops.size())
      for (int i = 0; i < exp_ops.size(); i++) check(name, oplog[i], exp_ops[i]);
  endtask

  // Physical memory: answers each strobe after 2..4 cycles with a one-cycle pmem_resp.
  initial begin : pmem_model
    int          wait_cnt;
    logic [15:0] a;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pmem_resp = 1'b0;
        wait_cnt  = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (wait_cnt == 0) wait_cnt = $urandom_range(2, 4);
        wait_cnt--;
        if (wait_cnt == 0) begin
          a = pmem_address;
          check("pmem_excl", {255'b0, pmem_read && pmem_write}, '0);
          check("pmem_align", a[4:0], 0);
          if (pmem_write) begin
            check("wb_data", pmem_wdata, get_arch(int'(a)));
            phys[int'(a)] = pmem_wdata;
            oplog.push_back({1'b1, a});
          end else begin
            pmem_rdata = get_phys(int'(a));
            oplog.push_back({1'b0, a});
          end
          pmem_resp = 1'b1;
        end
      end
    end
  end

  initial begin : resp_monitor
    exp_t e;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && mem_resp) begin
        check("resp_gap", {255'b0, prev_resp}, '0);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL resp_unexpected: got mem_resp with no request outstanding, expected none");
        end else begin
          e = sb.pop_front();
          if (!e.is_write) check("rdata", mem_rdata, e.data);
        end
      end
      prev_resp = reset_n && mem_resp;
    end
  end

  task automatic do_req(input logic [15:0] a, input bit wr, input logic [127:0] d,
                        output int cycles);
    exp_t         e;
    int           line;
    logic [255:0] l;
    bit           got;
    line = int'({a[15:5], 5'b0});
    @(negedge clk);
    mem_address = a;
    mem_wdata   = d;
    mem_write   = wr;
    mem_read    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    l = get_arch(line);
    e.is_write = wr;
    e.data     = a[4] ? l[255:128] : l[127:0];
    if (wr) begin
      if (a[4]) l[255:128] = d;
      else      l[127:0]   = d;
      arch[line] = l;
    end
    sb.push_back(e);
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < 400) begin
      @(negedge clk);
      cycles++;
      got = mem_resp;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout %h: got no mem_resp in %0d cycles, expected one", a, cycles);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 6 && n < 200) begin
      @(negedge clk);
      n++;
      if (pmem_read || pmem_write) q = 0;
      else q++;
    end
    if (q < 6) begin
      n_tests++;
      n_fail++;
      $display("FAIL quiet_timeout: got pmem traffic for %0d cycles, expected it to stop", n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    check("rst_mem_resp", mem_resp, 0);
    check("rst_pmem_rw", {pmem_read, pmem_write}, 0);
    check("rst_pmem_addr", pmem_address, 0);
    check("rst_counters", {hit_count, miss_count}, 0);
    @(negedge clk);
    @(negedge clk);
    arch = phys;
    sb.delete();
    oplog.delete();
    reset_n = 1'b1;
  endtask

  initial begin : stimulus
    int n;
    reset_n     = 1'b0;
    mem_address = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;

    // Read miss with upper-half data, then next-line prefetch.
    do_reset();
    do_req(16'h1230, 1'b0, '0, lat);
    wait_quiet();
    exp_ops.delete();
    exp_ops.push_back(17'h0_1220);
    exp_ops.push_back(17'h0_1240);
    check_log("t039_ops");
    check("t039_miss", miss_count, 1);
    check("t039_hit", hit_count, 0);

    // Write then read-hit on the second cycle.
    do_reset();
    do_req(16'h1200, 1'b1, {16{8'hA5}}, lat);
    wait_quiet();
    oplog.delete();
    do_req(16'h1200, 1'b0, '0, lat);
    check("t040_latency", lat, 1);
    wait_quiet();
    exp_ops.delete();
    exp_ops.push_back(17'h0_1220);
    check_log("t040_ops");
    check("t040_hit", hit_count, 1);
    check("t040_miss", miss_count, 1);

    // Four dirty lines in set 0, a fifth tag evicts the least recent (0x0000).
    do_reset();
    for (int t = 0; t < 4; t++) do_req(16'(t << 8), 1'b1, {4{$urandom}}, lat);
    oplog.delete();
    do_req(16'h0400, 1'b0, '0, lat);
    wait_quiet();
    exp_ops.delete();
    exp_ops.push_back(17'h1_0000);
    exp_ops.push_back(17'h0_0400);
    exp_ops.push_back(17'h0_0420);
    check_log("t041_ops");
    check("t041_miss", miss_count, 5);
    check("t041_hit", hit_count, 0);

    // Top line: no prefetch past the wrap point.
    do_reset();
    do_req(16'hFFE0, 1'b0, '0, lat);
    wait_quiet();
    exp_ops.delete();
    exp_ops.push_back(17'h0_FFE0);
    check_log("t042_ops");
    do_req(16'hFFF0, 1'b0, '0, lat);
    check("t042_hit_latency", lat, 1);

    // Reset during the line fill aborts it; the same read misses again.
    do_reset();
    @(negedge clk);
    mem_address = 16'h3000;
    mem_read    = 1'b1;
    n = 0;
    while (!pmem_read && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t043_alloc_seen", pmem_read, 1);
    reset_n  = 1'b0;
    mem_read = 1'b0;
    #1;
    check("t043_pmem_read_drop", pmem_read, 0);
    check("t043_pmem_addr", pmem_address, 0);
    @(negedge clk);
    @(negedge clk);
    arch = phys;
    sb.delete();
    oplog.delete();
    reset_n = 1'b1;
    do_req(16'h3000, 1'b0, '0, lat);
    wait_quiet();
    check("t043_miss_again", miss_count, 1);
    exp_ops.delete();
    exp_ops.push_back(17'h0_3000);
    exp_ops.push_back(17'h0_3020);
    check_log("t043_ops");

    // Random traffic over six tags so sets overflow and dirty lines get evicted.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      logic [15:0] a;
      a = {8'h10 + 8'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 4'h0};
      do_req(a, ($urandom_range(0, 99) < 40), {$urandom, $urandom, $urandom, $urandom}, lat);
    end
    wait_quiet();
    check("rand_access_count", 32'(hit_count) + 32'(miss_count), 250);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got no completion by 2ms, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
